// File: rtl/aps6404_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : aps6404_spi_responder_if
// Purpose  : PSRAM SPI bus bundle between a PSRAM controller (master) and
//            the APS6404 emulating responder (slave).
// Signals  : spiclk - SPI clock, mode 0, idles low      (master -> slave)
//            mosi   - serial data to responder, MSB first (master -> slave)
//            ce_    - chip enable, active low            (master -> slave)
//            miso   - serial data from responder         (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface aps6404_spi_responder_if;
   logic spiclk;
   logic mosi;
   logic ce_;
   logic miso;

   modport master (
      output spiclk,
      output mosi,
      output ce_,
      input  miso
   );

   modport slave (
      input  spiclk,
      input  mosi,
      input  ce_,
      output miso
   );
endinterface : aps6404_spi_responder_if
`default_nettype wire

// File: rtl/aps6404_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : aps6404_spi_responder
// Purpose  : Emulates the APS6404 PSRAM SPI command subset (RSTEN/RST,
//            READID, READ, WRITE) backed by a small internal byte array.
//            All bus inputs are oversampled in the sysclk domain, so the
//            SPI clock must be at most sysclk/8.
// Ports    : sysclk    - system clock, all logic on its rising edge
//            rst       - asynchronous active-high reset
//            spi       - SPI bus (spiclk, mosi, ce_ in; miso out)
//            cmd_q     - last fully received command byte
//            rst_count - accepted RSTEN->RST sequences, saturating
//            active    - high while a transaction is in progress
// Revision : 1.0 - initial release
// ============================================================================
module aps6404_spi_responder #(
   parameter int          ADDR_W = 10,
   parameter logic [7:0]  MFID   = 8'h0D,
   parameter logic [7:0]  KGD    = 8'h5D,
   parameter logic [47:0] EID    = 48'h0123456789AB
) (
   input  logic                    sysclk,
   input  logic                    rst,
   aps6404_spi_responder_if.slave  spi,
   output logic [7:0]              cmd_q,
   output logic [7:0]              rst_count,
   output logic                    active
);

   localparam int               DEPTH      = 1 << ADDR_W;
   localparam logic [7:0]       CMD_RSTEN  = 8'h66;
   localparam logic [7:0]       CMD_RST    = 8'h99;
   localparam logic [7:0]       CMD_READID = 8'h9F;
   localparam logic [7:0]       CMD_READ   = 8'h03;
   localparam logic [7:0]       CMD_WRITE  = 8'h02;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_SINK = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_ID = 2'd0,
      MODE_RD = 2'd1,
      MODE_WR = 2'd2
   } mode_t;

   // ---------------------------------------------------------------------
   // Input synchronisers. Index 1 is the synchronised sample, index 2 the
   // previous sample used for edge detection.
   // ---------------------------------------------------------------------
   logic [2:0] sclk_sync;
   logic [1:0] mosi_sync;
   logic [2:0] ce_sync;

   // ce_ synchronisers reset low: if ce_ is already low when reset is
   // released no falling edge is seen, so the responder waits for a fresh
   // ce_ fall instead of joining a transaction midway.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sclk_sync <= 3'b000;
         mosi_sync <= 2'b00;
         ce_sync   <= 3'b000;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi.spiclk};
         mosi_sync <= {mosi_sync[0], spi.mosi};
         ce_sync   <= {ce_sync[1:0], spi.ce_};
      end
   end

   logic sclk_rise, sclk_fall, ce_fall, ce_rise, mosi_s;
   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign ce_fall   = ~ce_sync[1] & ce_sync[2];
   assign ce_rise   = ce_sync[1] & ~ce_sync[2];
   assign mosi_s    = mosi_sync[1];

   // ---------------------------------------------------------------------
   // Datapath state
   // ---------------------------------------------------------------------
   state_t      state, state_next;
   mode_t       mode;
   logic [6:0]  shreg;
   logic [2:0]  bitcnt;
   logic [23:0] addr;
   logic [1:0]  addr_cnt;
   logic [7:0]  obyte;
   logic [3:0]  id_idx;
   logic        miso_q;
   logic        rsten_armed;
   logic [7:0]  mem [DEPTH];

   logic [7:0]  byte_in;
   logic        byte_done;
   logic [23:0] addr_shift;
   logic [23:0] addr_inc;
   logic [7:0]  id_next;
   logic        mem_we;

   // The completing byte includes the bit arriving on this very rise.
   assign byte_in    = {shreg, mosi_s};
   assign byte_done  = sclk_rise && (bitcnt == 3'd7) && (state != ST_IDLE);
   assign addr_shift = {addr[15:0], byte_in};
   // Only the low ADDR_W bits count, so the top location wraps to zero.
   assign addr_inc   = {addr[23:ADDR_W], addr[ADDR_W-1:0] + ADDR_ONE};

   assign spi.miso   = miso_q;

   // READID byte sequence after MFID: KGD, then EID MSB-first, then zeros.
   always_comb begin
      id_next = 8'h00;
      case (id_idx)
         4'd1:    id_next = KGD;
         4'd2:    id_next = EID[47:40];
         4'd3:    id_next = EID[39:32];
         4'd4:    id_next = EID[31:24];
         4'd5:    id_next = EID[23:16];
         4'd6:    id_next = EID[15:8];
         4'd7:    id_next = EID[7:0];
         default: id_next = 8'h00;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: state register and next-state logic
   // ---------------------------------------------------------------------
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      // A ce_ rise outranks a byte completing on the same cycle.
      if (ce_rise) begin
         state_next = ST_IDLE;
      end else if (ce_fall) begin
         state_next = ST_CMD;
      end else if (byte_done) begin
         case (state)
            ST_CMD: begin
               case (byte_in)
                  CMD_READID, CMD_READ, CMD_WRITE: state_next = ST_ADDR;
                  default:                         state_next = ST_SINK;
               endcase
            end
            ST_ADDR: begin
               if (addr_cnt == 2'd2) state_next = ST_DATA;
            end
            ST_DATA: begin
               mem_we = (mode == MODE_WR);
            end
            default: state_next = state;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Shift registers, address/ID tracking and status outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         mode        <= MODE_ID;
         shreg       <= 7'd0;
         bitcnt      <= 3'd0;
         addr        <= 24'd0;
         addr_cnt    <= 2'd0;
         obyte       <= 8'h00;
         id_idx      <= 4'd0;
         miso_q      <= 1'b0;
         rsten_armed <= 1'b0;
         cmd_q       <= 8'h00;
         rst_count   <= 8'h00;
         active      <= 1'b0;
      end else if (ce_rise) begin
         // Drop any partial byte; rsten_armed deliberately survives.
         active <= 1'b0;
         miso_q <= 1'b0;
         bitcnt <= 3'd0;
         obyte  <= 8'h00;
      end else if (ce_fall) begin
         active   <= 1'b1;
         miso_q   <= 1'b0;
         bitcnt   <= 3'd0;
         obyte    <= 8'h00;
         addr_cnt <= 2'd0;
         id_idx   <= 4'd0;
      end else if (state != ST_IDLE) begin
         if (sclk_rise) begin
            shreg  <= byte_in[6:0];
            bitcnt <= bitcnt + 3'd1;
         end
         if (sclk_fall) begin
            miso_q <= obyte[7];
            obyte  <= {obyte[6:0], 1'b0};
         end
         // obyte is reloaded here so its MSB appears on the next fall.
         if (byte_done) begin
            case (state)
               ST_CMD: begin
                  cmd_q       <= byte_in;
                  obyte       <= 8'h00;
                  addr_cnt    <= 2'd0;
                  rsten_armed <= (byte_in == CMD_RSTEN);
                  if ((byte_in == CMD_RST) && rsten_armed) begin
                     if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
                     addr <= 24'd0;
                  end
                  case (byte_in)
                     CMD_READID: mode <= MODE_ID;
                     CMD_READ:   mode <= MODE_RD;
                     CMD_WRITE:  mode <= MODE_WR;
                     default:    mode <= mode;
                  endcase
               end
               ST_ADDR: begin
                  addr     <= addr_shift;
                  addr_cnt <= addr_cnt + 2'd1;
                  obyte    <= 8'h00;
                  if (addr_cnt == 2'd2) begin
                     case (mode)
                        MODE_RD: obyte <= mem[addr_shift[ADDR_W-1:0]];
                        MODE_ID: begin
                           obyte  <= MFID;
                           id_idx <= 4'd1;
                        end
                        default: obyte <= 8'h00;
                     endcase
                  end
               end
               ST_DATA: begin
                  case (mode)
                     MODE_RD: begin
                        addr  <= addr_inc;
                        obyte <= mem[addr_inc[ADDR_W-1:0]];
                     end
                     MODE_ID: begin
                        obyte <= id_next;
                        if (id_idx != 4'd8) id_idx <= id_idx + 4'd1;
                     end
                     default: begin
                        addr  <= addr_inc;
                        obyte <= 8'h00;
                     end
                  endcase
               end
               default: obyte <= 8'h00;
            endcase
         end
      end
   end

   // Array contents are intentionally not reset.
   always_ff @(posedge sysclk) begin
      if (mem_we) mem[addr[ADDR_W-1:0]] <= byte_in;
   end

endmodule : aps6404_spi_responder
`default_nettype wire
